// File: rtl/sar_pkg.sv
// Shared definitions for the SAR conversion sequencer: FSM encoding,
// averaging-length mapping and accumulator sizing.
package sar_pkg;

  localparam int ACC_W = 11;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REQ  = 3'd1;
  localparam logic [2:0] ST_CONV = 3'd2;
  localparam logic [2:0] ST_PUSH = 3'd3;
  localparam logic [2:0] ST_WAIT = 3'd4;

  // Burst length N = 1, 2, 4, 8 for avg_sel = 0..3.
  function automatic logic [3:0] avg_n(input logic [1:0] sel);
    return 4'd1 << sel;
  endfunction

endpackage

// File: rtl/sar_result_fifo.sv
// Result FIFO: pointer-pair FIFO with an extra wrap bit, head presented
// combinationally, simultaneous push/pop allowed when full.
module sar_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign do_pop  = rd_en && !empty;
  assign do_push = wr_en && (!full || do_pop);
  assign rd_data = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
    end
  end

  // NOTE: storage is deliberately not reset; rd_data is forced to zero while
  // empty, so stale entries are never observable and the array stays plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/sar_sequencer.sv
// SAR conversion sequencer: issues go/sample handshakes, averages a burst of
// N results, pushes the average into a result FIFO, optionally re-triggers.
module sar_sequencer
  import sar_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64,
  parameter int PERIOD_W   = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont,
  input  logic [PERIOD_W-1:0] period,
  input  logic [1:0]          avg_sel,
  output logic                go,
  input  logic                sample,
  input  logic                valid,
  input  logic [7:0]          result,
  input  logic                rd_en,
  output logic [7:0]          rd_data,
  output logic                rd_empty,
  output logic                fifo_full,
  output logic                overflow,
  output logic                timeout_err,
  output logic                busy
);

  localparam int                TO_W    = $clog2(TIMEOUT) + 1;
  localparam logic [TO_W-1:0]   TO_LAST = TO_W'(TIMEOUT - 1);

  logic [2:0]          state;
  logic [2:0]          state_n;
  logic [ACC_W-1:0]    acc;
  logic [3:0]          cnt;
  logic [1:0]          sel_q;
  logic [TO_W-1:0]     tcnt;
  logic [PERIOD_W-1:0] wcnt;
  logic                begin_burst;
  logic                to_hit;
  logic                last_conv;
  logic                wait_done;
  logic                push;
  logic [7:0]          push_data;

  assign go        = (state == ST_REQ);
  assign busy      = (state != ST_IDLE);
  assign push      = (state == ST_PUSH);
  assign push_data = 8'(acc >> sel_q);
  assign to_hit    = (tcnt == TO_LAST);
  assign last_conv = ((cnt + 4'd1) == avg_n(sel_q));
  assign wait_done = (wcnt == period - PERIOD_W'(1));

  always_comb begin
    // NOTE: every output of this block is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    state_n     = state;
    begin_burst = 1'b0;
    case (state)
      ST_IDLE: if (start) begin_burst = 1'b1;
      ST_REQ: begin
        if (to_hit)      state_n = ST_IDLE;
        else if (sample) state_n = ST_CONV;
      end
      ST_CONV: begin
        if (valid)       state_n = last_conv ? ST_PUSH : ST_REQ;
        else if (to_hit) state_n = ST_IDLE;
      end
      ST_PUSH: begin
        if (!cont)              state_n = ST_IDLE;
        else if (period == '0) begin_burst = 1'b1;
        else                    state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (!cont)          state_n = ST_IDLE;
        else if (wait_done) begin_burst = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase
    if (begin_burst) state_n = ST_REQ;
  end

  // NOTE: all registered state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      acc         <= '0;
      cnt         <= '0;
      sel_q       <= '0;
      tcnt        <= '0;
      wcnt        <= '0;
      overflow    <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state <= state_n;
      wcnt  <= (state == ST_WAIT) ? wcnt + PERIOD_W'(1) : '0;

      // avg_sel is latched once per burst so mid-burst changes cannot skew N.
      if (begin_burst) begin
        acc   <= '0;
        cnt   <= '0;
        tcnt  <= '0;
        sel_q <= avg_sel;
      end else if (state == ST_CONV && valid) begin
        acc  <= acc + {3'b000, result};
        cnt  <= cnt + 4'd1;
        tcnt <= '0;
      end else if (state == ST_REQ || state == ST_CONV) begin
        tcnt <= tcnt + TO_W'(1);
      end

      if ((state == ST_REQ || (state == ST_CONV && !valid)) && to_hit)
        timeout_err <= 1'b1;
      if (push && fifo_full && !rd_en)
        overflow <= 1'b1;
    end
  end

  sar_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (push),
    .wr_data (push_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (rd_empty),
    .full    (fifo_full)
  );

endmodule

// File: tb/tb_sar_sequencer.sv
// Self-checking bench for sar_sequencer: randomized controller model, a
// queue-based reference of FIFO contents, and a monitor checking every pop.
module tb_sar_sequencer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        cont;
  logic [15:0] period;
  logic [1:0]  avg_sel;
  logic        go;
  logic        sample;
  logic        valid;
  logic [7:0]  result;
  logic        rd_en;
  logic [7:0]  rd_data;
  logic        rd_empty;
  logic        fifo_full;
  logic        overflow;
  logic        timeout_err;
  logic        busy;

  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         go_rises = 0;
  logic       go_prev  = 1'b0;
  logic [7:0] exp_q [$];
  int         dir_q [$];
  int         occ      = 0;
  logic       exp_ovf  = 1'b0;
  logic [7:0] mon_exp;

  sar_sequencer #(
    .FIFO_DEPTH (DEPTH),
    .TIMEOUT    (64),
    .PERIOD_W   (16)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .cont        (cont),
    .period      (period),
    .avg_sel     (avg_sel),
    .go          (go),
    .sample      (sample),
    .valid       (valid),
    .result      (result),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_empty    (rd_empty),
    .fifo_full   (fifo_full),
    .overflow    (overflow),
    .timeout_err (timeout_err),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (go === 1'b1 && go_prev !== 1'b1) go_rises <= go_rises + 1;
    go_prev <= go;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Monitor: every accepted pop must present the oldest expected average.
  always @(negedge clk) begin
    if (rst === 1'b0 && rd_en === 1'b1 && rd_empty === 1'b0) begin
      if (exp_q.size() > 0) mon_exp = exp_q.pop_front();
      else                  mon_exp = 'x;
      check("fifo_head", {24'd0, rd_data}, {24'd0, mon_exp});
    end
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference FIFO: averages enter in order; a push into a full FIFO is lost
  // unless the same cycle also pops.
  task automatic model_push(input int v, input bit popped);
    if (popped) exp_q.push_back(8'(v));
    else if (occ < DEPTH) begin
      exp_q.push_back(8'(v));
      occ++;
    end else exp_ovf = 1'b1;
  endtask

  task automatic check_flags(input string tag);
    check({tag, "_empty"},    rd_empty,  occ == 0);
    check({tag, "_full"},     fifo_full, occ == DEPTH);
    check({tag, "_overflow"}, overflow,  exp_ovf);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    check("rst_go", go, 0);
    check("rst_busy", busy, 0);
    check("rst_empty", rd_empty, 1);
    check("rst_full", fifo_full, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_overflow", overflow, 0);
    check("rst_timeout", timeout_err, 0);
    rst = 1'b0;
    exp_q.delete();
    occ     = 0;
    exp_ovf = 1'b0;
  endtask

  // Controller model, request side: wait for go, then acknowledge with sample.
  task automatic req_phase();
    int t = 0;
    while (go !== 1'b1 && t < 200) begin tick(); t++; end
    check("go_req", go, 1);
    repeat ($urandom_range(0, 3)) begin
      valid  = 1'($urandom);
      result = 8'($urandom);
      tick();
      check("go_hold", go, 1);
    end
    valid  = 1'b0;
    sample = 1'b1;
    tick();
    sample = 1'b0;
    check("go_drop", go, 0);
  endtask

  // Controller model, conversion side: deliver one result after a random delay.
  task automatic conv_phase(input logic [7:0] res, output int vc);
    repeat ($urandom_range(0, 3)) begin
      sample = 1'($urandom);
      start  = 1'($urandom);
      tick();
    end
    sample = 1'b0;
    start  = 1'b0;
    valid  = 1'b1;
    result = res;
    vc     = cyc;
    tick();
    valid  = 1'b0;
    result = 8'($urandom);
  endtask

  task automatic single_burst(input logic [1:0] sel, input bit pop_at_push);
    int n, sum, r, vc, rises0;
    n      = 1 << sel;
    sum    = 0;
    rises0 = go_rises;
    avg_sel = sel;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    avg_sel = 2'($urandom);
    for (int i = 0; i < n; i++) begin
      r = (dir_q.size() > 0) ? dir_q.pop_front() : int'($urandom_range(0, 255));
      sum += r;
      req_phase();
      conv_phase(8'(r), vc);
    end
    if (pop_at_push) rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    model_push(sum / n, pop_at_push);
    check("handshakes", go_rises - rises0, n);
    check("idle_after_burst", busy, 0);
    check_flags("burst");
  endtask

  task automatic drain();
    int t = 0;
    int expect_n = occ;
    while (rd_empty !== 1'b1 && t < 20) begin
      rd_en = 1'b1;
      tick();
      t++;
    end
    rd_en = 1'b0;
    check("drain_count", t, expect_n);
    check("drain_left", exp_q.size(), 0);
    occ = 0;
  endtask

  // Continuous mode: the gap from the burst's final valid to the next go rise
  // is one PUSH cycle, p WAIT cycles, then go in the first REQ cycle.
  task automatic cont_test(input int p);
    int vc, t, r;
    cont    = 1'b1;
    period  = 16'(p);
    avg_sel = 2'd0;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    for (int b = 0; b < 3; b++) begin
      r = $urandom_range(0, 255);
      req_phase();
      conv_phase(8'(r), vc);
      model_push(r, 1'b0);
      t = 0;
      while (go !== 1'b1 && t < 100) begin tick(); t++; end
      check("cont_gap", cyc - vc, p + 2);
    end
    cont = 1'b0;
    r = $urandom_range(0, 255);
    req_phase();
    conv_phase(8'(r), vc);
    model_push(r, 1'b0);
    tick();
    check("cont_end_idle", busy, 0);
    check_flags("cont");
  endtask

  initial begin
    int vc, t, g, r;
    rst = 1'b1; start = 1'b0; cont = 1'b0; period = '0; avg_sel = '0;
    sample = 1'b0; valid = 1'b0; result = '0; rd_en = 1'b0;
    repeat (2) tick();
    do_reset();

    // Single shot returning 64.
    dir_q = '{64};
    single_burst(2'd0, 1'b0);
    check("single_rd_data", rd_data, 64);
    drain();

    // Four-sample average: (10+11+12+13)/4 = 11.
    dir_q = '{10, 11, 12, 13};
    single_burst(2'd2, 1'b0);
    check("avg_rd_data", rd_data, 11);
    drain();

    // Random bursts of every length.
    for (int i = 0; i < 6; i++) begin
      single_burst(2'($urandom), 1'b0);
      if (i % 2 == 1) drain();
    end

    // Continuous mode with a non-zero and a zero period.
    cont_test(5);
    drain();
    cont_test(0);
    drain();

    // cont dropped while waiting ends the sequence.
    cont = 1'b1; period = 16'd10; avg_sel = 2'd0;
    start = 1'b1; tick(); start = 1'b0;
    r = $urandom_range(0, 255);
    req_phase();
    conv_phase(8'(r), vc);
    model_push(r, 1'b0);
    tick();
    check("wait_busy", busy, 1);
    cont = 1'b0;
    tick();
    check("wait_abort_idle", busy, 0);
    repeat (12) tick();
    check("wait_abort_no_go", go_prev, 0);
    drain();

    // Overflow: four pushes fill the FIFO, the fifth is dropped.
    for (int i = 0; i < 5; i++) single_burst(2'($urandom), 1'b0);
    check("ovf_full", fifo_full, 1);
    check("ovf_flag", overflow, 1);
    drain();
    check("ovf_sticky", overflow, 1);
    do_reset();

    // Push and pop together while full keep occupancy and lose nothing.
    for (int i = 0; i < 4; i++) single_burst(2'd0, 1'b0);
    single_burst(2'd1, 1'b1);
    check("pushpop_full", fifo_full, 1);
    check("pushpop_no_ovf", overflow, 0);
    drain();

    // Timeout: second conversion of a burst never completes.
    check("to_clear_before", timeout_err, 0);
    avg_sel = 2'd1; start = 1'b1; tick(); start = 1'b0;
    req_phase();
    conv_phase(8'($urandom), vc);
    t = 0;
    while (go !== 1'b1 && t < 100) begin tick(); t++; end
    g = cyc;
    repeat (2) tick();
    sample = 1'b1; tick(); sample = 1'b0;
    t = 0;
    while (timeout_err !== 1'b1 && t < 200) begin tick(); t++; end
    check("timeout_cycles", cyc - g, 64);
    check("timeout_idle", busy, 0);
    check("timeout_fifo_empty", rd_empty, 1);
    repeat (3) tick();
    check("timeout_sticky", timeout_err, 1);

    // Reset in CONV of an 8-sample burst abandons it without a push.
    avg_sel = 2'd3; start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_phase();
      conv_phase(8'($urandom), vc);
    end
    req_phase();
    do_reset();
    valid = 1'b1; result = 8'hff; tick(); valid = 1'b0;
    repeat (5) tick();
    check("rst_no_restart", busy, 0);
    check("rst_no_push", rd_empty, 1);
    single_burst(2'd3, 1'b0);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sar_sequencer.md
SAR_SEQUENCER -- requirements
Module: sar_sequencer

Interface
REQ-001 Parameters SHALL be: FIFO_DEPTH, 4, result FIFO entries (power of 2); TIMEOUT, 64, max cycles from go-accept to valid; PERIOD_W, 16, width of the continuous-mode period counter.
REQ-002 Ports, in this order, SHALL be:
- clk  in  1  single clock, all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a burst.
- cont  in  1  level; 1 = re-trigger continuously, 0 = single burst.
- period  in  PERIOD_W  idle cycles between bursts in continuous mode.
- avg_sel  in  2  burst length N = 1, 2, 4, 8 for 0..3.
- go  out  1  conversion request to the SAR controller.
- sample  in  1  controller sample phase; acknowledges go.
- valid  in  1  controller conversion-done strobe.
- result  in  8  controller conversion result, qualified by valid.
- rd_en  in  1  FIFO pop.
- rd_data  out  8  FIFO head, valid while rd_empty = 0.
- rd_empty  out  1  FIFO empty.
- fifo_full  out  1  FIFO full.
- overflow  out  1  sticky; an averaged result was dropped.
- timeout_err  out  1  sticky; valid not seen within TIMEOUT.
- busy  out  1  high in every state except IDLE.

Function
REQ-003 FSM states SHALL be IDLE, REQ, CONV, PUSH, WAIT.
REQ-004 IDLE: start=1 SHALL clear the accumulator and sample count and move to REQ; start seen in any other state SHALL be ignored.
REQ-005 REQ: go SHALL be 1 and SHALL stay 1 until the first cycle with sample=1; that cycle SHALL move to CONV, with go=0 from the next cycle.
REQ-006 CONV: the first cycle with valid=1 SHALL add result (zero-extended) into an 11-bit accumulator and increment the sample count; if count = N, move to PUSH, else return to REQ.
REQ-007 The timeout counter SHALL count cycles spent in REQ and CONV within one conversion and SHALL reset at each valid; on reaching TIMEOUT it SHALL set timeout_err, discard the burst, and go to IDLE.
REQ-008 PUSH: the averaged value SHALL be accumulator >> avg_sel (truncating) and SHALL be written to the FIFO in one cycle; if the FIFO is full and rd_en=0, the value SHALL be dropped and overflow set.
REQ-009 A push and a pop in the same cycle when the FIFO is full SHALL both succeed, leaving occupancy unchanged.
REQ-010 After PUSH: with cont=1, move to WAIT; with cont=0, move to IDLE.
REQ-011 WAIT SHALL last exactly period cycles and then enter REQ with the accumulator cleared; period=0 SHALL go straight to REQ on the next cycle; cont=0 sampled in WAIT SHALL return to IDLE.
REQ-012 avg_sel SHALL be captured at the start of each burst; changes during a burst SHALL have no effect on it.
REQ-013 FIFO: rd_data SHALL be the head, combinational from storage; rd_en with rd_empty=1 SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH, with one extra bit to tell full from empty.
REQ-014 valid outside CONV and sample outside REQ SHALL be ignored.

Reset
REQ-015 rst=1 SHALL, on the next edge, force: IDLE; go=0; busy=0; FIFO empty (rd_empty=1, fifo_full=0, rd_data=0); overflow=0; timeout_err=0; all counters and the accumulator cleared.
REQ-016 rst asserted mid-burst SHALL abandon the conversion without pushing; after release, start is required again.
REQ-017 Sticky flags SHALL clear only on rst.

Structure
REQ-018 A shared package sar_pkg SHALL hold the FSM state encoding, the avg_sel-to-N mapping, and the accumulator width constant (11).
REQ-019 The FIFO SHALL be a separate sub-module, sar_result_fifo (depth and width parameterised), instantiated once.

Verification
REQ-020 Single shot: avg_sel=0, cont=0, start pulse, controller model returns 64 -> one go/sample handshake, rd_data=64, rd_empty=0, FSM back in IDLE, busy=0.
REQ-021 Averaging: avg_sel=2, results 10, 11, 12, 13 -> four handshakes, FIFO receives 11 (46>>2).
REQ-022 Continuous mode: cont=1, period=5 -> exactly 5 WAIT cycles between PUSH and the next go rise, checked over 3 bursts.
REQ-023 Overflow: 5 single-shot bursts with no rd_en -> fifo_full=1 after 4 pushes, overflow=1 after the 5th, FIFO contents are the first four results.
REQ-024 Timeout: model never asserts valid -> timeout_err=1 after 64 cycles, FSM in IDLE, FIFO unchanged.
REQ-025 Reset mid-burst: rst in CONV with avg_sel=3 -> go=0, rd_empty=1 on the next edge, no push; a following start runs a clean burst.
